// File: rtl/log_decompression_if.sv
// ============================================================================
// Module   : log_decompression_if
// Purpose  : Frame request / linear-energy result bundle for log_decompression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface log_decompression_if #(
   parameter int N_FILTERS = 40,
   parameter int LOG_WIDTH = 6,
   parameter int LIN_WIDTH = 28,
   parameter int CNT_WIDTH = 6
);
   logic                           start;
   logic [LOG_WIDTH*N_FILTERS-1:0] log_energy_flat;
   logic [LIN_WIDTH*N_FILTERS-1:0] lin_energy_flat;
   logic                           busy;
   logic                           done;
   logic [CNT_WIDTH-1:0]           sat_count;

   modport master (
      output start, log_energy_flat,
      input  lin_energy_flat, busy, done, sat_count
   );

   modport slave (
      input  start, log_energy_flat,
      output lin_energy_flat, busy, done, sat_count
   );
endinterface

`default_nettype wire

// File: rtl/log_decompression.sv
// ============================================================================
// Module   : log_decompression
// Purpose  : Expands a frame of log2 codes into linear energies, one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_decompression #(
   parameter int N_FILTERS = 40,
   parameter int LOG_WIDTH = 6,
   parameter int LIN_WIDTH = 28,
   parameter int CNT_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   log_decompression_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_last_idx = CNT_WIDTH'(N_FILTERS - 1);
   localparam logic [LIN_WIDTH-1:0] c_one      = LIN_WIDTH'(1);

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [LOG_WIDTH*N_FILTERS-1:0] r_frame;
   logic [LIN_WIDTH*N_FILTERS-1:0] r_lin;
   logic [CNT_WIDTH-1:0]           r_idx;
   logic [CNT_WIDTH-1:0]           r_sat;

   logic [LOG_WIDTH-1:0]           w_code;
   logic [LIN_WIDTH-1:0]           w_lin;
   logic                           w_sat;

   // Decode of the entry currently addressed by r_idx.
   always_comb begin
      w_code = r_frame[int'(r_idx)*LOG_WIDTH +: LOG_WIDTH];
      w_sat  = (int'(w_code) >= LIN_WIDTH);
      w_lin  = '0;
      if (w_code == '0)
         w_lin = '0;
      else if (w_sat)
         w_lin = '1;
      else
         w_lin = c_one << w_code;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = RUN;
         RUN:     if (r_idx == c_last_idx) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Frame capture happens only on an accepted start; starts in RUN/DONE fall through.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame <= '0;
         r_lin   <= '0;
         r_idx   <= '0;
         r_sat   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_frame <= bus.log_energy_flat;
                  r_idx   <= '0;
                  r_sat   <= '0;
               end
            end
            RUN: begin
               r_lin[int'(r_idx)*LIN_WIDTH +: LIN_WIDTH] <= w_lin;
               r_idx <= r_idx + CNT_WIDTH'(1);
               if (w_sat)
                  r_sat <= r_sat + CNT_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy            = (r_state == RUN);
   assign bus.done            = (r_state == DONE);
   assign bus.lin_energy_flat = r_lin;
   assign bus.sat_count       = r_sat;

endmodule

`default_nettype wire

// File: doc/log_decompression.md
LOG_DECOMPRESSION -- requirements
Module: log_decompression

Interface
REQ-001 Parameter N_FILTERS, default 40: number of filter-bank channels per frame.
REQ-002 Parameter LOG_WIDTH, default 6: width of each log2 code.
REQ-003 Parameter LIN_WIDTH, default 28: width of each reconstructed linear energy.
REQ-004 Parameter CNT_WIDTH, default 6: width of index and saturation counters; the SHALL hold N_FILTERS.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle request to decode the frame present on log_energy_flat.
REQ-008 log_energy_flat  input  LOG_WIDTH*N_FILTERS  packed log2 codes; entry i at bits [(i+1)*LOG_WIDTH-1 -: LOG_WIDTH].
REQ-009 lin_energy_flat  output  LIN_WIDTH*N_FILTERS  packed linear energies; entry i at bits [(i+1)*LIN_WIDTH-1 -: LIN_WIDTH].
REQ-010 busy  output  1  high while a frame is being decoded.
REQ-011 done  output  1  one-cycle pulse; lin_energy_flat is complete and stable.
REQ-012 sat_count  output  CNT_WIDTH  number of entries in the last frame that saturated.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE, registered.
REQ-014 IDLE: when start=1 is sampled, the block SHALL copy log_energy_flat into an internal frame register, clear idx and sat_count to 0, set busy=1 and go to RUN.
REQ-015 The input SHALL be sampled only at that edge; later changes to log_energy_flat SHALL NOT affect the frame.
REQ-016 RUN: on each edge the block SHALL decode entry idx, write it to lin_energy_flat slot idx and increment idx; exactly one entry per cycle.
REQ-017 Decode rule: code c=0 SHALL give 0.
REQ-018 Decode rule: 1 <= c <= LIN_WIDTH-1 SHALL give 1<<c, zero-extended to LIN_WIDTH.
REQ-019 Decode rule: c >= LIN_WIDTH SHALL give all-ones (saturation) and increment sat_count.
REQ-020 At the edge that writes entry N_FILTERS-1, the block SHALL go to DONE, set busy=0 and done=1.
REQ-021 DONE SHALL last one cycle; the next edge SHALL clear done and return to IDLE. done SHALL therefore be a single-cycle pulse.
REQ-022 Latency: start sampled at edge k means entries 0..N-1 are written at edges k+1..k+N, and done is high in the cycle following edge k+N.
REQ-023 start while busy=1 or in DONE SHALL be ignored; the block does not queue requests.
REQ-024 A start in IDLE immediately after DONE SHALL be accepted normally (back-to-back frames, N+2 cycles apart).
REQ-025 lin_energy_flat SHALL hold its value outside RUN. During RUN, slots not yet rewritten SHALL keep the previous frame's values.
REQ-026 sat_count SHALL hold its value until the next accepted start.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, idx=0, busy=0, done=0, sat_count=0, lin_energy_flat=0 and frame register=0.
REQ-028 rst SHALL take priority over start and over any in-progress RUN. An aborted frame SHALL NOT produce done.
REQ-029 With rst=1 and start=1 on the same edge, reset SHALL win and the start SHALL be dropped.

Verification
REQ-030 Scenario: all codes=5, start pulse -> done exactly 41 cycles after the start edge, every slot = 32, sat_count=0.
REQ-031 Scenario: entry i = i mod 28 (others 0) -> slot 0 = 0, slot 1 = 2, slot 27 = 2^27, slots 28..39 follow the same mapping.
REQ-032 Scenario: entries 0..3 = 28, 31, 63, 27, rest 0 -> slots 0..2 = 0xFFFFFFF, slot 3 = 0x8000000, sat_count=3.
REQ-033 Scenario: start again at cycles 5 and 20 of RUN, plus log_energy_flat changed mid-frame -> both ignored; output matches the original frame; one done pulse only.
REQ-034 Scenario: rst asserted at cycle 10 of RUN -> next cycle all outputs 0 and state IDLE; no done; a new start then completes normally in 41 cycles.
REQ-035 Scenario: two frames started back-to-back (second start in the cycle after done) -> two done pulses 42 cycles apart; second output reflects only the second frame.
